// File: rtl/mem_resp_pkg.sv
// Shared encodings and defaults for the four-phase memory responder.
package mem_resp_pkg;

    localparam int DEF_ADDR_W      = 4;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_LATENCY     = 3;
    localparam int DEF_SYNC_STAGES = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [1:0] ST_FAULT  = 2'd3;

    localparam logic OP_WR = 1'b0;
    localparam logic OP_RD = 1'b1;

endpackage

// File: rtl/mem_resp_bit_sync.sv
// Multi-stage synchroniser for one asynchronous request strobe.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain_q <= '0;
        else     chain_q <= chain_d;
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/mem_resp.sv
// Memory-side responder: synchronised four-phase handshake in front of
// an internal RAM with per-word written flags and a fixed access latency.
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LATENCY     = DEF_LATENCY,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(LATENCY) + 1;

    logic wr_s;
    logic rd_s;

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (
        .clk (clk),
        .rst (rst),
        .d   (mem_write),
        .q   (wr_s)
    );

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
        .clk (clk),
        .rst (rst),
        .d   (mem_read),
        .q   (rd_s)
    );

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic              ram_we;
    logic              req_op;
    logic              req_opp;

    logic [DATA_W-1:0] ram [DEPTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        valid_d = valid_q;
        ram_we  = 1'b0;
        req_op  = (op_q == OP_WR) ? wr_s : rd_s;
        req_opp = (op_q == OP_WR) ? rd_s : wr_s;
        case (state_q)
            ST_IDLE: begin
                if (wr_s && rd_s) begin
                    state_d = ST_FAULT;
                    err_d   = 1'b1;
                end else if (wr_s) begin
                    state_d = ST_ACCESS;
                    op_d    = OP_WR;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end else if (rd_s) begin
                    state_d = ST_ACCESS;
                    op_d    = OP_RD;
                    addr_d  = mem_addr;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            ST_ACCESS: begin
                // A withdrawn request aborts before any RAM side effect
                if (!req_op) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    if (op_q == OP_WR) begin
                        ram_we          = 1'b1;
                        valid_d[addr_q] = 1'b1;
                    end else begin
                        rdata_d = valid_q[addr_q] ? ram[addr_q] : '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (req_opp) err_d = 1'b1;
                if (!req_op) state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (!wr_s && !rd_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_WR;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    // Contents are deliberately not reset; valid_q masks stale words
    always_ff @(posedge clk) begin
        if (ram_we) ram[addr_q] <= wdata_q;
    end

    assign mem_done  = done_q;
    assign mem_rdata = rdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_mem_resp.sv
// Directed table-driven bench for mem_resp plus hand-written corner sequences.
module tb_mem_resp;

    logic       clk;
    logic       rst;
    logic       mem_write;
    logic       mem_read;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_done;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    mem_resp dut (
        .clk       (clk),
        .rst       (rst),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       is_wr;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rdata;
        logic       scramble;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic txn(input vec_t v);
        int rise;
        int fall;
        @(negedge clk);
        mem_addr  = v.addr;
        mem_wdata = v.data;
        mem_write = v.is_wr;
        mem_read  = !v.is_wr;
        rise = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check("busy_before_access", busy, 0);
            if (v.scramble && k == 2) begin
                mem_addr  = ~v.addr;
                mem_wdata = ~v.data;
            end
            if (mem_done) begin
                rise = k;
                break;
            end
        end
        check("done_rise_edge", rise, 5);
        check("busy_at_done", busy, 1);
        check("err_clean", err, 0);
        if (!v.is_wr) check("rdata_at_done", mem_rdata, v.exp_rdata);
        @(negedge clk);
        mem_write = 1'b0;
        mem_read  = 1'b0;
        fall = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (!mem_done) begin
                fall = k;
                break;
            end
        end
        check("done_fall_edge", fall, 2);
        check("busy_after_fall", busy, 0);
        if (!v.is_wr) check("rdata_held", mem_rdata, v.exp_rdata);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_done"}, mem_done, 0);
        check({name, "_rdata"}, mem_rdata, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_err"}, err, 0);
    endtask

    initial begin
        vec_t rd;
        logic seen_done;

        vecs[0] = '{1'b1, 4'd3,  8'hA5, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 4'd3,  8'h00, 8'hA5, 1'b0};
        vecs[2] = '{1'b0, 4'd7,  8'h00, 8'h00, 1'b0};
        vecs[3] = '{1'b1, 4'd3,  8'h5A, 8'h00, 1'b0};
        vecs[4] = '{1'b0, 4'd3,  8'h00, 8'h5A, 1'b0};
        vecs[5] = '{1'b1, 4'd15, 8'hFF, 8'h00, 1'b0};
        vecs[6] = '{1'b0, 4'd15, 8'h00, 8'hFF, 1'b0};
        vecs[7] = '{1'b1, 4'd4,  8'h77, 8'h00, 1'b1};
        vecs[8] = '{1'b0, 4'd4,  8'h00, 8'h77, 1'b1};
        vecs[9] = '{1'b0, 4'd11, 8'h00, 8'h00, 1'b0};

        rst       = 1'b1;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) txn(vecs[i]);

        // write withdrawn during ACCESS must abort without a RAM update
        @(negedge clk);
        mem_addr  = 4'd2;
        mem_wdata = 8'h3C;
        mem_write = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy", busy, 1);
        @(negedge clk);
        mem_write = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (mem_done) seen_done = 1'b1;
        end
        check("abort_no_done", seen_done, 0);
        check("abort_err", err, 1);
        check("abort_idle", busy, 0);
        rd = '{1'b0, 4'd2, 8'h00, 8'h00, 1'b0};
        @(negedge clk);
        mem_addr = 4'd2;
        mem_read = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("abort_rd_done", mem_done, 1);
        check("abort_rd_data", mem_rdata, rd.exp_rdata);
        @(negedge clk);
        mem_addr = 4'd3;
        mem_read = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        mem_read = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("abort_other_word", mem_rdata, 8'h5A);
        @(negedge clk);
        mem_read = 1'b0;
        repeat (4) @(posedge clk);

        @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_outputs("rst_clears_err");
        @(negedge clk);
        rst = 1'b0;

        // simultaneous requests
        @(negedge clk);
        mem_addr  = 4'd5;
        mem_write = 1'b1;
        mem_read  = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (mem_done) seen_done = 1'b1;
        end
        check("fault_err", err, 1);
        check("fault_busy", busy, 1);
        check("fault_no_done", seen_done, 0);
        @(negedge clk);
        mem_write = 1'b0;
        mem_read  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("fault_exit", busy, 0);
        check("fault_err_sticky", err, 1);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // async reset during a write access
        @(negedge clk);
        mem_addr  = 4'd1;
        mem_wdata = 8'h99;
        mem_write = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("rst_mid");
        @(negedge clk);
        mem_write = 1'b0;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        rd = '{1'b0, 4'd1, 8'h00, 8'h00, 1'b0};
        txn(rd);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
